// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial add/subtract engine. A start request in IDLE captures the
// operands. One full-adder cell then processes a bit per clock, LSB first,
// for WIDTH clocks. The parallel result is published with a one-cycle done
// pulse.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous reset, active-low
//   start  - operation request, honoured only in IDLE
//   A, B   - operands, captured on an accepted start
//   Cin    - carry-in for add (ignored for subtract)
//   Sub    - 0 = add, 1 = subtract (A + ~B + 1)
//   busy   - high while bits are being shifted
//   done   - one-cycle pulse when S/C have just been updated
//   C      - carry-out of the last operation (no-borrow flag for subtract)
//   S      - sum/difference of the last operation

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic             C,
  output logic [WIDTH-1:0] S
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               c_q, c_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sum_bit;
  logic               carry_out;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    c_d       = c_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // The single full-adder cell, operating on the current operand LSBs.
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract is performed as A + ~B + 1, so B is inverted up front
          // and the carry is forced to 1 in place of Cin.
          a_d     = A;
          b_d     = B ^ {WIDTH{Sub}};
          carry_d = Sub ? 1'b1 : Cin;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Sum bits enter at the MSB so after WIDTH steps the first bit has
        // drifted down to bit 0.
        acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          s_d     = {sum_bit, acc_q[WIDTH-1:1]};
          c_d     = carry_out;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        // A start seen here is deliberately dropped.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign C    = c_q;
  assign S    = s_q;

endmodule
